// File: rtl/dct_entry_writer.sv
// dct_entry_writer
// Collects the 8-byte ENTDAA payload (PID, BCR, DCR) from the bus receiver.
// Merges it with the assigned dynamic address and issues one 128-bit
// write to the Device Characteristic Table at the latched index.
module dct_entry_writer #(
    parameter int DCT_SIZE = 128
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [$clog2(DCT_SIZE)-1:0] index_i,
    input  logic [6:0]                  dyn_addr_i,
    input  logic                        abort_i,
    input  logic                        byte_valid_i,
    input  logic [7:0]                  byte_data_i,
    output logic                        byte_ready_o,
    output logic                        dct_write_valid_o,
    input  logic                        dct_write_ready_i,
    output logic [$clog2(DCT_SIZE)-1:0] dct_index_o,
    output logic [127:0]                dct_wdata_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        aborted_o
);

    localparam int IDX_W = $clog2(DCT_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    // Payload bytes in arrival order: byte 0 occupies [63:56], byte 7 occupies [7:0].
    // This leaves PID = [63:16], BCR = [15:8] and DCR = [7:0].
    logic [63:0]      payload_q, payload_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [6:0]       dyn_q, dyn_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [5:0]       byte_lsb;

    // Bit offset of the byte slot addressed by the counter: 8 * (7 - cnt).
    assign byte_lsb = {~cnt_q, 3'b000};

    // Next-state, payload capture and pulse generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        index_d   = index_q;
        dyn_d     = dyn_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = COLLECT;
                    index_d   = index_i;
                    dyn_d     = dyn_addr_i;
                    cnt_d     = 3'd0;
                    payload_d = '0;
                end
            end
            COLLECT: begin
                // An abort in the same cycle as a byte drops that byte.
                if (abort_i) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (byte_valid_i) begin
                    payload_d[byte_lsb +: 8] = byte_data_i;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // The entry is complete, so abort_i is ignored here.
                if (dct_write_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial entry silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            payload_q <= '0;
            index_q   <= '0;
            dyn_q     <= 7'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
            index_q   <= index_d;
            dyn_q     <= dyn_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign byte_ready_o      = (state_q == COLLECT);
    assign dct_write_valid_o = (state_q == WRITE);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;
    assign aborted_o         = aborted_q;
    assign dct_index_o       = index_q;

    // DCT entry layout: word0 = PID[47:16], word1[15:0] = PID[15:0],
    // word2 = {BCR, DCR} in the low half, word3[6:0] = dynamic address.
    assign dct_wdata_o = {25'd0, dyn_q,
                          16'd0, payload_q[15:8], payload_q[7:0],
                          16'd0, payload_q[31:16],
                          payload_q[63:32]};

endmodule

// File: tb/tb_dct_entry_writer.sv
// Self-checking bench for dct_entry_writer: a scoreboard of expected DCT
// writes is compared by a write monitor, while each scenario task checks
// its own handshake timing and pulses.
module tb_dct_entry_writer;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [6:0]   index_i;
    logic [6:0]   dyn_addr_i;
    logic         abort_i;
    logic         byte_valid_i;
    logic [7:0]   byte_data_i;
    logic         byte_ready_o;
    logic         dct_write_valid_o;
    logic         dct_write_ready_i;
    logic [6:0]   dct_index_o;
    logic [127:0] dct_wdata_o;
    logic         busy_o;
    logic         done_o;
    logic         aborted_o;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;

    typedef struct packed {
        logic [6:0]   idx;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];

    dct_entry_writer #(.DCT_SIZE(128)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .index_i           (index_i),
        .dyn_addr_i        (dyn_addr_i),
        .abort_i           (abort_i),
        .byte_valid_i      (byte_valid_i),
        .byte_data_i       (byte_data_i),
        .byte_ready_o      (byte_ready_o),
        .dct_write_valid_o (dct_write_valid_o),
        .dct_write_ready_i (dct_write_ready_i),
        .dct_index_o       (dct_index_o),
        .dct_wdata_o       (dct_wdata_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .aborted_o         (aborted_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] model(input logic [47:0] pid, input logic [7:0] bcr,
                                           input logic [7:0] dcr, input logic [6:0] dyn);
        logic [127:0] d;
        d = '0;
        d[31:0]   = pid[47:16];
        d[47:32]  = pid[15:0];
        d[71:64]  = dcr;
        d[79:72]  = bcr;
        d[102:96] = dyn;
        return d;
    endfunction

    // Write monitor: inputs change #1 after posedge, so at negedge they show
    // what the next posedge will see.
    always @(negedge clk_i) begin
        if (!rst_i && dct_write_valid_o === 1'b1 && dct_write_ready_i === 1'b1) begin
            exp_t e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got idx=%0d data=%h required none", dct_index_o, dct_wdata_o);
            end else begin
                e = exp_q.pop_front();
                if (dct_index_o !== e.idx || dct_wdata_o !== e.data) begin
                    failures++;
                    $display("FAIL write_data got idx=%0d data=%h required idx=%0d data=%h",
                             dct_index_o, dct_wdata_o, e.idx, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [6:0] idx, input logic [6:0] dyn);
        start_i    = 1'b1;
        index_i    = idx;
        dyn_addr_i = dyn;
        tick();
        start_i    = 1'b0;
        index_i    = 7'($urandom);
        dyn_addr_i = 7'($urandom);
    endtask

    // Drives the 8 payload bytes with optional random gaps. When inject_at
    // matches a byte number, a spurious start (index 9) rides along with it.
    task automatic collect(input logic [47:0] pid, input logic [7:0] bcr, input logic [7:0] dcr,
                           input int gap_max, input int inject_at);
        logic [63:0] p;
        p = {pid, bcr, dcr};
        for (int i = 0; i < 8; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                byte_valid_i = 1'b0;
                byte_data_i  = 8'($urandom);
                tick();
            end
            if (i == inject_at) begin
                start_i    = 1'b1;
                index_i    = 7'd9;
                dyn_addr_i = 7'h7F;
            end
            byte_valid_i = 1'b1;
            byte_data_i  = p[63-8*i -: 8];
            tick();
            start_i = 1'b0;
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({byte_ready_o, dct_write_valid_o, busy_o, done_o, aborted_o} !== 5'b0 ||
            dct_index_o !== 7'd0 || dct_wdata_o !== 128'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b done=%b abt=%b idx=%0d data=%h required all 0",
                     byte_ready_o, dct_write_valid_o, busy_o, done_o, aborted_o, dct_index_o, dct_wdata_o);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b rdy=%b required 0 0", busy_o, byte_ready_o);
        end
    endtask

    task automatic test_nominal();
        logic [7:0] b [8];
        int cycles;
        bit early;
        b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hC6, 8'h3F};
        dct_write_ready_i = 1'b1;
        exp_q.push_back('{idx: 7'd5, data: model(48'h0123_4567_89AB, 8'hC6, 8'h3F, 7'h2A)});
        do_start(7'd5, 7'h2A);
        cycles = 1;
        checks++;
        if (byte_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL start_to_ready got rdy=%b busy=%b required 1 1", byte_ready_o, busy_o);
        end
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (dct_write_valid_o !== 1'b0 || byte_ready_o !== 1'b1) early = 1'b1;
            byte_valid_i = 1'b1;
            byte_data_i  = b[i];
            tick();
            cycles++;
        end
        byte_valid_i = 1'b0;
        checks++;
        if (early || dct_write_valid_o !== 1'b1 || cycles != 9) begin
            failures++;
            $display("FAIL write_latency got vld=%b cycles=%0d early=%b required vld=1 cycles=9 early=0",
                     dct_write_valid_o, cycles, early);
        end
        checks++;
        if (dct_index_o !== 7'd5 || dct_wdata_o !== 128'h0000002A_0000C63F_000089AB_01234567) begin
            failures++;
            $display("FAIL nominal_data got idx=%0d data=%h required idx=5 data=0000002a0000c63f000089ab01234567",
                     dct_index_o, dct_wdata_o);
        end
        tick();
        checks++;
        if (dct_write_valid_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got vld=%b done=%b busy=%b required 0 1 0", dct_write_valid_o, done_o, busy_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle got done=%b required 0", done_o);
        end
    endtask

    task automatic test_stall();
        logic [6:0]   idx_h;
        logic [127:0] dat_h;
        int           w0;
        dct_write_ready_i = 1'b0;
        exp_q.push_back('{idx: 7'd17, data: model(48'hDEAD_BEEF_1234, 8'h5A, 8'hA5, 7'h55)});
        do_start(7'd17, 7'h55);
        collect(48'hDEAD_BEEF_1234, 8'h5A, 8'hA5, 0, -1);
        idx_h = dct_index_o;
        dat_h = dct_wdata_o;
        w0    = writes;
        for (int c = 0; c < 10; c++) begin
            abort_i = (c == 4);
            tick();
            checks++;
            if (dct_write_valid_o !== 1'b1 || dct_index_o !== idx_h || dct_wdata_o !== dat_h) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got vld=%b idx=%0d data=%h required vld=1 idx=%0d data=%h",
                         c, dct_write_valid_o, dct_index_o, dct_wdata_o, idx_h, dat_h);
            end
        end
        abort_i = 1'b0;
        dct_write_ready_i = 1'b1;
        tick();
        checks++;
        if (dct_write_valid_o !== 1'b0 || done_o !== 1'b1 || writes != w0 + 1) begin
            failures++;
            $display("FAIL stall_release got vld=%b done=%b writes=%0d required 0 1 %0d",
                     dct_write_valid_o, done_o, writes, w0 + 1);
        end
        tick();
    endtask

    task automatic test_abort();
        int w0;
        dct_write_ready_i = 1'b1;
        w0 = writes;
        // Abort after four bytes.
        do_start(7'd40, 7'h01);
        for (int i = 0; i < 4; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'(i + 1);
            tick();
        end
        byte_valid_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if (aborted_o !== 1'b1 || busy_o !== 1'b0 || dct_write_valid_o !== 1'b0 || byte_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_mid got abt=%b busy=%b vld=%b rdy=%b required 1 0 0 0",
                     aborted_o, busy_o, dct_write_valid_o, byte_ready_o);
        end
        tick();
        checks++;
        if (aborted_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_one_cycle got abt=%b required 0", aborted_o);
        end
        // Abort coincident with the 8th byte.
        do_start(7'd41, 7'h02);
        for (int i = 0; i < 8; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'(8'h10 + i);
            abort_i      = (i == 7);
            tick();
        end
        byte_valid_i = 1'b0;
        abort_i      = 1'b0;
        checks++;
        if (aborted_o !== 1'b1 || busy_o !== 1'b0 || dct_write_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_last_byte got abt=%b busy=%b vld=%b required 1 0 0",
                     aborted_o, busy_o, dct_write_valid_o);
        end
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (writes != w0 || aborted_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_write got writes=%0d abt=%b required %0d 0", writes, aborted_o, w0);
        end
    endtask

    task automatic test_ignored_start();
        int n;
        dct_write_ready_i = 1'b0;
        exp_q.push_back('{idx: 7'd33, data: model(48'hCAFE_F00D_5AA5, 8'h81, 8'h42, 7'h11)});
        do_start(7'd33, 7'h11);
        collect(48'hCAFE_F00D_5AA5, 8'h81, 8'h42, 2, 2);
        n = 0;
        while (dct_write_valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (dct_write_valid_o !== 1'b1 || dct_index_o !== 7'd33) begin
            failures++;
            $display("FAIL ignored_start got vld=%b idx=%0d required vld=1 idx=33", dct_write_valid_o, dct_index_o);
        end
        dct_write_ready_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = writes;
        // Reset three bytes into COLLECT.
        dct_write_ready_i = 1'b0;
        do_start(7'd77, 7'h3C);
        for (int i = 0; i < 3; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i  = 8'hE0 + 8'(i);
            tick();
        end
        rst_i = 1'b1;
        tick();
        byte_valid_i = 1'b0;
        checks++;
        if ({byte_ready_o, dct_write_valid_o, busy_o, done_o, aborted_o} !== 5'b0 ||
            dct_index_o !== 7'd0 || dct_wdata_o !== 128'd0) begin
            failures++;
            $display("FAIL reset_collect got rdy=%b vld=%b busy=%b idx=%0d data=%h required all 0",
                     byte_ready_o, dct_write_valid_o, busy_o, dct_index_o, dct_wdata_o);
        end
        rst_i = 1'b0;
        // Reset while a write is stalled.
        do_start(7'd78, 7'h3D);
        collect(48'h1111_2222_3333, 8'h44, 8'h55, 0, -1);
        checks++;
        if (dct_write_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_write_setup got vld=%b required 1", dct_write_valid_o);
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if ({byte_ready_o, dct_write_valid_o, busy_o, done_o, aborted_o} !== 5'b0 ||
            dct_index_o !== 7'd0 || dct_wdata_o !== 128'd0) begin
            failures++;
            $display("FAIL reset_write got vld=%b busy=%b done=%b idx=%0d data=%h required all 0",
                     dct_write_valid_o, busy_o, done_o, dct_index_o, dct_wdata_o);
        end
        rst_i = 1'b0;
        dct_write_ready_i = 1'b1;
        tick();
        checks++;
        if (done_o !== 1'b0 || aborted_o !== 1'b0 || writes != w0) begin
            failures++;
            $display("FAIL reset_no_pulse got done=%b abt=%b writes=%0d required 0 0 %0d",
                     done_o, aborted_o, writes, w0);
        end
        // A full capture after reset must still be correct.
        exp_q.push_back('{idx: 7'd79, data: model(48'h0F0E_0D0C_0B0A, 8'h09, 8'h08, 7'h7E)});
        do_start(7'd79, 7'h7E);
        collect(48'h0F0E_0D0C_0B0A, 8'h09, 8'h08, 0, -1);
        tick();
        checks++;
        if (done_o !== 1'b1 || writes != w0 + 1) begin
            failures++;
            $display("FAIL reset_recover got done=%b writes=%0d required 1 %0d", done_o, writes, w0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        dct_write_ready_i = 1'b1;
        w0 = writes;
        exp_q.push_back('{idx: 7'd0, data: model(48'hA1A2_A3A4_A5A6, 8'hB1, 8'hC1, 7'h10)});
        exp_q.push_back('{idx: 7'd127, data: model(48'h5152_5354_5556, 8'h61, 8'h71, 7'h20)});
        do_start(7'd0, 7'h10);
        collect(48'hA1A2_A3A4_A5A6, 8'hB1, 8'hC1, 0, -1);
        tick();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_done got done=%b busy=%b required 1 0", done_o, busy_o);
        end
        do_start(7'd127, 7'h20);
        checks++;
        if (byte_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got rdy=%b busy=%b required 1 1", byte_ready_o, busy_o);
        end
        collect(48'h5152_5354_5556, 8'h61, 8'h71, 0, -1);
        tick();
        checks++;
        if (done_o !== 1'b1 || writes != w0 + 2) begin
            failures++;
            $display("FAIL b2b_second got done=%b writes=%0d required 1 %0d", done_o, writes, w0 + 2);
        end
        tick();
    endtask

    initial begin
        rst_i             = 1'b1;
        start_i           = 1'b0;
        index_i           = 7'd0;
        dyn_addr_i        = 7'd0;
        abort_i           = 1'b0;
        byte_valid_i      = 1'b0;
        byte_data_i       = 8'd0;
        dct_write_ready_i = 1'b0;
        test_reset();
        test_nominal();
        test_stall();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_writes got %0d outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
